calc_operand_entry: RTL

- Operand-entry front end for the 3-bit add/multiply 7-segment calculator chip.
- Turns three raw, bouncy pushbuttons into registered 3-bit operands A and B plus the show/op-select controls.
- Drives the display decoder stage directly downstream: its a0..a2, b0..b2, show and sw outputs connect one-to-one to that stage's inputs.
- Adds debouncing, a sequencing FSM and an optional auto-return timeout.

---
 rtl/calc_operand_entry_if.sv | 23 ++
 rtl/calc_operand_entry.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/calc_operand_entry_if.sv
// Button inputs and display-decoder outputs of the calculator operand-entry stage.
// The entry block takes the slave side; whatever drives the buttons takes master.
interface calc_operand_entry_if;
   logic btn_inc;
   logic btn_next;
   logic btn_op;
   logic a0, a1, a2;
   logic b0, b1, b2;
   logic show;
   logic sw;
   logic edit_a;
   logic edit_b;

   modport master (
      output btn_inc, btn_next, btn_op,
      input  a0, a1, a2, b0, b1, b2, show, sw, edit_a, edit_b
   );

   modport slave (
      input  btn_inc, btn_next, btn_op,
      output a0, a1, a2, b0, b1, b2, show, sw, edit_a, edit_b
   );
endinterface

// File: rtl/calc_operand_entry.sv
// Operand entry for the 3-bit add/multiply calculator: synchronizes and debounces
// three pushbuttons, then sequences A/B entry, result display and op selection.
module calc_operand_entry #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int SHOW_TIMEOUT    = 0,
   parameter int TIMEOUT_W       = 24
) (
   input  logic                 clk,
   input  logic                 rst_n,
   calc_operand_entry_if.slave  io
);

   typedef enum logic [1:0] {
      ENTER_A = 2'd0,
      ENTER_B = 2'd1,
      SHOW    = 2'd2
   } state_e;

   localparam int NB       = 3;
   localparam int BTN_INC  = 0;
   localparam int BTN_NEXT = 1;
   localparam int BTN_OP   = 2;
   localparam int DB_W     = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [DB_W-1:0]      DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam bit                   TMO_EN   = (SHOW_TIMEOUT > 0);
   localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'((SHOW_TIMEOUT > 0) ? SHOW_TIMEOUT - 1 : 0);

   logic [NB-1:0]            btn_raw;
   logic [NB-1:0]            sync1_d, sync1_q;
   logic [NB-1:0]            sync2_d, sync2_q;
   logic [NB-1:0]            db_level_d, db_level_q;
   logic [NB-1:0][DB_W-1:0]  db_cnt_d, db_cnt_q;
   logic [NB-1:0]            evt_d, evt_q;

   state_e                   state_d, state_q;
   logic [2:0]               a_d, a_q;
   logic [2:0]               b_d, b_q;
   logic                     show_d, show_q;
   logic                     sw_d, sw_q;
   logic [TIMEOUT_W-1:0]     tmo_d, tmo_q;

   assign btn_raw = {io.btn_op, io.btn_next, io.btn_inc};

   // Debounce: count consecutive cycles the synchronized level disagrees with the
   // accepted level; a press event is the accepted level going 0->1.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      sync1_d    = btn_raw;
      sync2_d    = sync1_q;
      db_level_d = db_level_q;
      db_cnt_d   = '0;
      evt_d      = '0;
      for (int i = 0; i < NB; i++) begin
         if (sync2_q[i] != db_level_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               db_level_d[i] = sync2_q[i];
               evt_d[i]      = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      show_d  = show_q;
      sw_d    = sw_q;
      tmo_d   = '0;

      if (evt_q[BTN_OP]) sw_d = ~sw_q;

      // next always wins over inc; a timeout only fires when next is absent.
      unique case (state_q)
         ENTER_A: begin
            if (evt_q[BTN_NEXT])     state_d = ENTER_B;
            else if (evt_q[BTN_INC]) a_d = a_q + 3'd1;
         end
         ENTER_B: begin
            if (evt_q[BTN_NEXT]) begin
               state_d = SHOW;
               show_d  = 1'b1;
            end else if (evt_q[BTN_INC]) begin
               b_d = b_q + 3'd1;
            end
         end
         SHOW: begin
            if (evt_q[BTN_NEXT]) begin
               state_d = ENTER_A;
               a_d     = '0;
               b_d     = '0;
               show_d  = 1'b0;
            end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
               state_d = ENTER_A;
               show_d  = 1'b0;
            end else if (TMO_EN) begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: begin
            state_d = ENTER_A;
            show_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         db_level_q <= '0;
         db_cnt_q   <= '0;
         evt_q      <= '0;
         state_q    <= ENTER_A;
         a_q        <= '0;
         b_q        <= '0;
         show_q     <= 1'b0;
         sw_q       <= 1'b0;
         tmo_q      <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of its neighbours.
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         db_level_q <= db_level_d;
         db_cnt_q   <= db_cnt_d;
         evt_q      <= evt_d;
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         show_q     <= show_d;
         sw_q       <= sw_d;
         tmo_q      <= tmo_d;
      end
   end

   assign io.a0     = a_q[0];
   assign io.a1     = a_q[1];
   assign io.a2     = a_q[2];
   assign io.b0     = b_q[0];
   assign io.b1     = b_q[1];
   assign io.b2     = b_q[2];
   assign io.show   = show_q;
   assign io.sw     = sw_q;
   assign io.edit_a = (state_q == ENTER_A);
   assign io.edit_b = (state_q == ENTER_B);

endmodule
